jump_target_unit: RTL and testbench



---
 rtl/jtu_pkg.sv | 14 +
 rtl/jump_target_unit_if.sv | 28 ++
 rtl/jtu_ras.sv | 48 ++++
 rtl/jump_target_unit.sv | 113 +++++++++++
 tb/tb_jump_target_unit.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/jtu_pkg.sv
// Shared definitions for the jump target unit: op encodings and fixed field widths.
package jtu_pkg;

    typedef enum logic [1:0] {
        OP_J   = 2'b00,
        OP_JAL = 2'b01,
        OP_BR  = 2'b10,
        OP_JR  = 2'b11
    } jtu_op_e;

    localparam int BR_IMM_W = 16;
    localparam int LINK_OFS = 4;

endpackage

// File: rtl/jump_target_unit_if.sv
// Request/response bundle between decode, the jump target unit and the PC register.
interface jump_target_unit_if #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 26
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        op;
    logic [ADDR_W-1:0] pc;
    logic [IDX_W-1:0]  idx;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] link;
    logic              err;
    logic              ras_empty;
    logic              ras_full;

    modport master (
        output in_valid, op, pc, idx, out_ready,
        input  in_ready, out_valid, target, link, err, ras_empty, ras_full
    );

    modport slave (
        input  in_valid, op, pc, idx, out_ready,
        output in_ready, out_valid, target, link, err, ras_empty, ras_full
    );
endinterface

// File: rtl/jtu_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module jtu_ras #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] wdata,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] stack_q [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q;
    logic [CNT_W-1:0]  count_q;

    // ptr_q names the next free slot; wrapping it lets a push reuse the oldest slot.
    assign top   = stack_q[ptr_q - PTR_W'(1)];
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(RAS_DEPTH));

    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else if (push) begin
            ptr_q <= ptr_q + PTR_W'(1);
            if (!full) begin
                count_q <= count_q + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            ptr_q   <= ptr_q - PTR_W'(1);
            count_q <= count_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/jump_target_unit.sv
// Registered next-PC target unit for J/JAL/BR/JR with one cycle of latency.
// Define JTU_RAS_EN to build the return-address stack; otherwise every JR reports err.
module jump_target_unit
    import jtu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int IDX_W     = 26,
    parameter int SHIFT     = 2,
    parameter int RAS_DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    jump_target_unit_if.slave bus
);
    localparam logic [ADDR_W-1:0] HI_MASK = {ADDR_W{1'b1}} << (IDX_W + SHIFT);

    logic              in_ready;
    logic              accept;
    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] jmp_tgt;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] target_d, target_q;
    logic [ADDR_W-1:0] link_d, link_q;
    logic              err_d, err_q;
    logic              out_valid_q;
    logic              ras_empty_w;
    logic              ras_full_w;
    logic [ADDR_W-1:0] ras_top;

    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    assign pc4     = bus.pc + ADDR_W'(LINK_OFS);
    assign jmp_tgt = (pc4 & HI_MASK) | (ADDR_W'(bus.idx) << SHIFT);
    assign br_off  = {{(ADDR_W-BR_IMM_W){bus.idx[BR_IMM_W-1]}}, bus.idx[BR_IMM_W-1:0]} << SHIFT;

`ifdef JTU_RAS_EN
    logic ras_push;
    logic ras_pop;

    // The stack moves at acceptance, so a JR right behind a JAL sees its push.
    assign ras_push = accept && (bus.op == OP_JAL);
    assign ras_pop  = accept && (bus.op == OP_JR) && !ras_empty_w;

    jtu_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (ras_push),
        .pop   (ras_pop),
        .wdata (pc4),
        .top   (ras_top),
        .empty (ras_empty_w),
        .full  (ras_full_w)
    );
`else
    assign ras_empty_w = 1'b1;
    assign ras_full_w  = 1'b0;
    assign ras_top     = '0;
`endif

    always_comb begin
        target_d = jmp_tgt;
        link_d   = '0;
        err_d    = 1'b0;
        case (bus.op)
            OP_J: begin
                target_d = jmp_tgt;
            end
            OP_JAL: begin
                target_d = jmp_tgt;
                link_d   = pc4;
            end
            OP_BR: begin
                target_d = pc4 + br_off;
            end
            OP_JR: begin
                target_d = ras_empty_w ? pc4 : ras_top;
                err_d    = ras_empty_w;
            end
            default: begin
                target_d = jmp_tgt;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            target_q    <= '0;
            link_q      <= '0;
            err_q       <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            target_q    <= target_d;
            link_q      <= link_d;
            err_q       <= err_d;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.target    = target_q;
    assign bus.link      = link_q;
    assign bus.err       = err_q;
    assign bus.ras_empty = ras_empty_w;
    assign bus.ras_full  = ras_full_w;

endmodule

// File: tb/tb_jump_target_unit.sv
// Bench for jump_target_unit: directed literal cases plus randomized traffic against a queue-based model.
module tb_jump_target_unit;
    localparam int ADDR_W    = 32;
    localparam int IDX_W     = 26;
    localparam int SHIFT     = 2;
    localparam int RAS_DEPTH = 4;
`ifdef JTU_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jump_target_unit_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus();

    jump_target_unit #(
        .ADDR_W    (ADDR_W),
        .IDX_W     (IDX_W),
        .SHIFT     (SHIFT),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: what the outputs must show and the return addresses held.
    bit          live = 1'b0;
    bit          m_valid;
    logic [31:0] m_target;
    logic [31:0] m_link;
    logic        m_err;
    logic [31:0] ras [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            live     = 1'b1;
            m_valid  = 1'b0;
            m_target = '0;
            m_link   = '0;
            m_err    = 1'b0;
            ras.delete();
        end else if (live) begin
            if (bus.in_valid && (!m_valid || bus.out_ready)) begin
                logic [31:0] pc4;
                int          off;
                pc4     = bus.pc + 32'd4;
                m_valid = 1'b1;
                m_link  = '0;
                m_err   = 1'b0;
                case (bus.op)
                    2'b00, 2'b01: begin
                        m_target = {pc4[31:28], bus.idx, 2'b00};
                        if (bus.op == 2'b01) begin
                            m_link = pc4;
                            if (RAS_ON) begin
                                if (ras.size() == RAS_DEPTH) void'(ras.pop_front());
                                ras.push_back(pc4);
                            end
                        end
                    end
                    2'b10: begin
                        off      = int'($signed(bus.idx[15:0]));
                        m_target = pc4 + 32'(off * 4);
                    end
                    default: begin
                        if (RAS_ON && ras.size() > 0) begin
                            m_target = ras.pop_back();
                        end else begin
                            m_target = pc4;
                            m_err    = 1'b1;
                        end
                    end
                endcase
                $display("txn op=%0d pc=%h idx=%h -> target=%h link=%h err=%0d",
                         bus.op, bus.pc, bus.idx, m_target, m_link, m_err);
            end else if (bus.out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
            chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
            chk("ras_empty", 32'(bus.ras_empty), RAS_ON ? 32'(ras.size() == 0) : 32'd1);
            chk("ras_full", 32'(bus.ras_full), RAS_ON ? 32'(ras.size() == RAS_DEPTH) : 32'd0);
            if (m_valid) begin
                chk("target", bus.target, m_target);
                chk("link", bus.link, m_link);
                chk("err", 32'(bus.err), 32'(m_err));
            end
        end
    end

    task automatic cyc(input bit v, input logic [1:0] o, input logic [31:0] p, input logic [25:0] i);
        bus.in_valid = v;
        bus.op       = o;
        bus.pc       = p;
        bus.idx      = i;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_t;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.op        = 2'b00;
        bus.pc        = '0;
        bus.idx       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_target", bus.target, 32'd0);
        chk("rst_link", bus.link, 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_ras_empty", 32'(bus.ras_empty), 32'd1);
        chk("rst_ras_full", 32'(bus.ras_full), 32'd0);
        rst = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        cyc(1'b1, 2'b00, 32'h9000_0000, 26'h000_0100);
        chk("j_target", bus.target, 32'h9000_0400);
        chk("j_link", bus.link, 32'd0);
        chk("j_err", 32'(bus.err), 32'd0);
        chk("j_valid", 32'(bus.out_valid), 32'd1);

        cyc(1'b1, 2'b10, 32'h0000_1000, 26'h3FF_0003);
        chk("br_fwd", bus.target, 32'h0000_1010);
        cyc(1'b1, 2'b10, 32'h0000_1000, 26'h000_FFFF);
        chk("br_back", bus.target, 32'h0000_1000);
        cyc(1'b1, 2'b10, 32'hFFFF_FFFC, 26'h000_0001);
        chk("br_wrap", bus.target, 32'h0000_0004);
        cyc(1'b1, 2'b00, 32'hFFFF_FFFC, 26'h000_0003);
        chk("j_wrap", bus.target, 32'h0000_000C);

        cyc(1'b1, 2'b01, 32'h0000_0100, 26'h0);
        chk("jal_link", bus.link, 32'h0000_0104);
        chk("jal_empty", 32'(bus.ras_empty), RAS_ON ? 32'd0 : 32'd1);
        cyc(1'b1, 2'b11, 32'h0000_0200, 26'h0);
        chk("jr_target", bus.target, RAS_ON ? 32'h0000_0104 : 32'h0000_0204);
        chk("jr_err", 32'(bus.err), RAS_ON ? 32'd0 : 32'd1);
        chk("jr_empty", 32'(bus.ras_empty), 32'd1);

        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 2'b01, 32'(k * 16), 26'h0);
            chk("ovf_full", 32'(bus.ras_full), 32'(RAS_ON && k >= 3));
        end
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 2'b11, 32'h0000_0080, 26'h0);
            exp_t = (RAS_ON && k < 4) ? 32'(32'h44 - k * 16) : 32'h84;
            chk("unf_target", bus.target, exp_t);
            chk("unf_err", 32'(bus.err), 32'((!RAS_ON) || k == 4));
        end

        cyc(1'b1, 2'b01, 32'h0000_0300, 26'h5);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 2'b11, 32'h0000_0500, 26'h0);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_target", bus.target, 32'h0000_0014);
            chk("bp_link", bus.link, 32'h0000_0304);
            chk("bp_empty", 32'(bus.ras_empty), RAS_ON ? 32'd0 : 32'd1);
        end
        bus.out_ready = 1'b1;
        cyc(1'b1, 2'b11, 32'h0000_0500, 26'h0);
        chk("bp_rel_target", bus.target, RAS_ON ? 32'h0000_0304 : 32'h0000_0504);
        chk("bp_rel_err", 32'(bus.err), RAS_ON ? 32'd0 : 32'd1);

        cyc(1'b1, 2'b01, 32'h0000_0600, 26'h0);
        cyc(1'b1, 2'b01, 32'h0000_0700, 26'h0);
        bus.out_ready = 1'b0;
        cyc(1'b0, 2'b00, 32'h0, 26'h0);
        chk("mid_valid_held", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        cyc(1'b0, 2'b00, 32'h0, 26'h0);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_empty", 32'(bus.ras_empty), 32'd1);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        cyc(1'b1, 2'b11, 32'h0000_0800, 26'h0);
        chk("mid_jr_err", 32'(bus.err), 32'd1);
        chk("mid_jr_target", bus.target, 32'h0000_0804);

        for (int n = 0; n < 1500; n++) begin
            logic [1:0] o;
            int         sel;
            rst           = ($urandom_range(0, 199) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            sel           = int'($urandom_range(0, 9));
            o             = (sel < 4) ? 2'b01 : (sel < 8) ? 2'b11 : 2'($urandom_range(0, 3));
            cyc($urandom_range(0, 3) != 0, o, $urandom, 26'($urandom));
        end
        rst = 1'b0;
        bus.out_ready = 1'b1;
        cyc(1'b0, 2'b00, 32'h0, 26'h0);
        cyc(1'b0, 2'b00, 32'h0, 26'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
